countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- BCD countdown timer for the number game, running on refclk.
- Sits directly downstream of the divided-clock generator: that stage's slow outclk drives tick_in here, one tick per second.
- tick_in is sampled and synchronised, never used as a clock; each rising edge of tick_in decrements the count by one.
- Drives the seven-segment display digits and raises the round-timeout event to the game controller.

Parameters:
- DIGITS, 2, number of BCD digits in the count (count range 0 to 10^DIGITS-1).
- SYNC_STAGES, 2, synchroniser flop depth on tick_in (minimum 2).

Ports:
- refclk  input  1  system clock; all state changes on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- tick_in  input  1  divided clock from the divider stage; asynchronous to refclk in the general case.
- load  input  1  one-cycle strobe; copies load_value into the count and enters IDLE.
- load_value  input  4*DIGITS  BCD preset value; digit i is bits [4i+3:4i].
- start  input  1  one-cycle strobe; begins or resumes counting.
- pause  input  1  one-cycle strobe; freezes counting.
- clear  input  1  one-cycle strobe; sets the count to 0 and enters IDLE.
- count_bcd  output  4*DIGITS  current count in BCD.
- running  output  1  high while in RUN.
- expired  output  1  level; high while in EXPIRED.
- expire_pulse  output  1  single-cycle pulse on entering EXPIRED.

Behaviour:
- Reset, asynchronous:
  - count_bcd=0, running=0, expired=0, expire_pulse=0.
  - State=IDLE; all synchroniser and edge flops cleared to 0.
- Tick path:
  - tick_in passes through SYNC_STAGES flops, then one edge-history flop.
  - tick_en is a 1-cycle pulse when the synchronised value is 1 and the history flop is 0.
  - Latency from tick_in rise to tick_en: SYNC_STAGES+1 refclk edges.
  - The count changes on the edge that samples tick_en.
  - tick_in high at reset release yields one tick_en. That tick is harmless, because ticks are ignored outside RUN.
- States: IDLE, RUN, PAUSED, EXPIRED. running and expired are registered decodes of the state.
- Command priority within a cycle: clear > load > pause > start > tick_en. Only the highest-priority active item acts; the others are dropped.
- clear, any state: count=0, go to IDLE.
- load, any state: count=load_value, go to IDLE.
  - Any load_value digit >9 is clamped to 9 (example: 0xA5 loads as 0x95).
- start:
  - From IDLE or PAUSED with count≠0: go to RUN.
  - With count=0: go to EXPIRED and pulse expire_pulse.
  - Ignored in RUN and EXPIRED.
- pause: RUN to PAUSED; ignored in every other state.
- tick_en in RUN: BCD decrement of the count.
  - A digit at 0 borrows: it becomes 9 and the borrow propagates upward. Example: 0x10 becomes 0x09.
  - If the decremented value is 0: go to EXPIRED and set expire_pulse for exactly one cycle, registered together with count=0.
- tick_en in IDLE, PAUSED or EXPIRED: ignored. A tick coinciding with pause is lost (pause wins).
- EXPIRED is sticky: count holds 0 and expired stays high until clear or load. No wrap-around to 10^DIGITS-1.
- expire_pulse is 0 in every cycle except the entry cycle.
- resetn asserted mid-count: immediate return to reset values; no pulse is produced.

Decomposition:
- Shared package (number_game_pkg):
  - State encoding constants ST_IDLE=0, ST_RUN=1, ST_PAUSED=2, ST_EXPIRED=3.
  - BCD_MAX=4'd9.
  - BCD-digit width constant BCD_W=4.
- One sub-module, tick_sync_edge:
  - Contains the synchroniser and rising-edge detector.
  - Ports: refclk, resetn, async_in, edge_pulse.
  - Reusable for button inputs elsewhere in the game.
- The BCD decrement is a per-digit generate loop inside countdown_timer.

Test Plan:
- Reset with tick_in toggling every 10 refclk cycles: all outputs 0, count stays 0x00, no expire_pulse.
- load_value=0x12, load, then start, then 3 tick_in rises: count reads 0x11, 0x10, 0x09. Each change lands 3 refclk edges after its tick_in rise. running=1 throughout.
- load 0x02, start, run 2 ticks: count reaches 0x00 and expired=1. expire_pulse is high for exactly 1 cycle, in the same cycle count becomes 0. Further ticks leave count at 0x00.
- load 0x05, start, 1 tick (count 0x04), pause, 3 ticks, start, 1 tick: count holds 0x04 while PAUSED, then reaches 0x03. running reads 1, 0, 1 across the sequence.
- Simultaneous clear+load+start in one cycle with count=0x07 in RUN: count=0x00, state IDLE, no pulse.
- Separate case: load_value=0xAF loads as 0x99, then start with count=0x00 after clear gives immediate EXPIRED plus a one-cycle pulse.
- Assert resetn low while in RUN with count=0x30, tick pending in the synchroniser: all outputs 0 immediately. After release, no tick_en acts until a new start.

Source files
------------

// File: rtl/number_game_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | number_game_pkg: shared state encoding and BCD helpers.   Rev 1.0  |
// +--------------------------------------------------------------------+
package number_game_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_sync_edge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tick_sync_edge: synchroniser plus rising-edge pulse.      Rev 1.0  |
// +--------------------------------------------------------------------+
module tick_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic refclk,
  input  logic resetn,
  input  logic async_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge refclk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  // Combinational so the consumer acts on the edge after the history flop lags.
  assign edge_pulse = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | countdown_timer: BCD countdown with run/pause/expire.     Rev 1.0  |
// +--------------------------------------------------------------------+
module countdown_timer
  import number_game_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  refclk,
  input  logic                  resetn,
  input  logic                  tick_in,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  running,
  output logic                  expired,
  output logic                  expire_pulse
);

  localparam int CW = BCD_W * DIGITS;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic            r_running;
  logic            r_expired;
  logic            r_expire_pulse;

  logic            w_tick_en;
  logic [CW-1:0]   w_dec;
  logic [CW-1:0]   w_load_clamped;
  logic [DIGITS-1:0] w_borrow;
  state_t          w_state_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic            w_pulse_nxt;

  tick_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_tick_sync (
    .refclk     (refclk),
    .resetn     (resetn),
    .async_in   (tick_in),
    .edge_pulse (w_tick_en)
  );

  assign w_borrow[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [BCD_W-1:0] w_dig;
    assign w_dig = r_count[i*BCD_W +: BCD_W];
    assign w_dec[i*BCD_W +: BCD_W] =
      !w_borrow[i]        ? w_dig :
      (w_dig == 4'd0)     ? BCD_MAX : w_dig - 4'd1;
    assign w_load_clamped[i*BCD_W +: BCD_W] = bcd_clamp(load_value[i*BCD_W +: BCD_W]);
    if (i < DIGITS - 1) begin : g_borrow
      assign w_borrow[i+1] = w_borrow[i] && (w_dig == 4'd0);
    end
  end

  // Strict priority: clear > load > pause > start > tick; an active item blocks all below it.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_pulse_nxt = 1'b0;
    if (clear) begin
      w_count_nxt = '0;
      w_state_nxt = ST_IDLE;
    end else if (load) begin
      w_count_nxt = w_load_clamped;
      w_state_nxt = ST_IDLE;
    end else if (pause) begin
      if (r_state == ST_RUN) w_state_nxt = ST_PAUSED;
    end else if (start) begin
      if (r_state == ST_IDLE || r_state == ST_PAUSED) begin
        if (r_count == '0) begin
          w_state_nxt = ST_EXPIRED;
          w_pulse_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
    end else if (w_tick_en && r_state == ST_RUN) begin
      w_count_nxt = w_dec;
      if (w_dec == '0) begin
        w_state_nxt = ST_EXPIRED;
        w_pulse_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge refclk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= ST_IDLE;
      r_count        <= '0;
      r_running      <= 1'b0;
      r_expired      <= 1'b0;
      r_expire_pulse <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_count        <= w_count_nxt;
      r_running      <= (w_state_nxt == ST_RUN);
      r_expired      <= (w_state_nxt == ST_EXPIRED);
      r_expire_pulse <= w_pulse_nxt;
    end
  end

  assign count_bcd    = r_count;
  assign running      = r_running;
  assign expired      = r_expired;
  assign expire_pulse = r_expire_pulse;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_countdown_timer: scoreboard bench for countdown_timer. Rev 1.0  |
// +--------------------------------------------------------------------+
module tb_countdown_timer;

  logic       refclk = 1'b0;
  logic       resetn = 1'b0;
  logic       tick_in = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'h00;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] count_bcd;
  logic       running;
  logic       expired;
  logic       expire_pulse;

  int n_cmp = 0;
  int n_mis = 0;
  int pulse_cnt = 0;
  logic [7:0] exp_q[$];

  countdown_timer #(.DIGITS(2), .SYNC_STAGES(2)) dut (
    .refclk       (refclk),
    .resetn       (resetn),
    .tick_in      (tick_in),
    .load         (load),
    .load_value   (load_value),
    .start        (start),
    .pause        (pause),
    .clear        (clear),
    .count_bcd    (count_bcd),
    .running      (running),
    .expired      (expired),
    .expire_pulse (expire_pulse)
  );

  always #5 refclk = ~refclk;

  always @(negedge refclk) if (resetn && expire_pulse === 1'b1) pulse_cnt++;

  task automatic step();
    @(posedge refclk); #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load_value = v; load = 1'b1; step(); load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  // Raise tick_in, watch up to 8 edges for a count change, then drop it and let it settle.
  task automatic tick_wait(output int lat, output logic [7:0] obs, output logic pulse_at);
    logic [7:0] prev;
    prev = count_bcd; lat = 0; pulse_at = 1'b0; obs = count_bcd;
    tick_in = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (lat == 0 && count_bcd !== prev) begin
        lat = k; obs = count_bcd; pulse_at = expire_pulse;
      end
    end
    if (lat == 0) obs = count_bcd;
    tick_in = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 40; c++) begin
      if (c % 10 == 0) tick_in = ~tick_in;
      step();
      if (c % 10 == 5) begin
        n_cmp++;
        if ({count_bcd, running, expired, expire_pulse} !== 11'd0) begin
          n_mis++;
          $display("FAIL reset_hold: got count=%h run=%b exp=%b pulse=%b, need all 0",
                   count_bcd, running, expired, expire_pulse);
        end
      end
    end
    tick_in = 1'b0;
    @(negedge refclk); resetn = 1'b1;
    repeat (6) step();
    n_cmp++;
    if (count_bcd !== 8'h00 || running !== 1'b0 || pulse_cnt !== 0) begin
      n_mis++;
      $display("FAIL reset_release: got count=%h run=%b pulses=%0d, need 00/0/0",
               count_bcd, running, pulse_cnt);
    end
  endtask

  task automatic test_countdown();
    int lat; logic [7:0] obs; logic p; logic [7:0] e;
    do_load(8'h12); do_start();
    n_cmp++;
    if (running !== 1'b1) begin n_mis++; $display("FAIL cd_running_start: got %b need 1", running); end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(i == 0 ? 8'h11 : i == 1 ? 8'h10 : 8'h09);
      tick_wait(lat, obs, p);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_mis++; $display("FAIL cd_count[%0d]: got %h need %h", i, obs, e); end
      n_cmp++;
      if (lat !== 3) begin n_mis++; $display("FAIL cd_latency[%0d]: got %0d need 3", i, lat); end
      n_cmp++;
      if (running !== 1'b1) begin n_mis++; $display("FAIL cd_running[%0d]: got %b need 1", i, running); end
    end
  endtask

  task automatic test_expire();
    int lat; logic [7:0] obs; logic p; logic [7:0] e; int pc0;
    do_load(8'h02); do_start();
    pc0 = pulse_cnt;
    exp_q.push_back(8'h01);
    tick_wait(lat, obs, p);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_mis++; $display("FAIL exp_count1: got %h need %h", obs, e); end
    exp_q.push_back(8'h00);
    tick_wait(lat, obs, p);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e || p !== 1'b1) begin
      n_mis++; $display("FAIL exp_zero: got count=%h pulse=%b need %h/1", obs, p, e);
    end
    n_cmp++;
    if (expired !== 1'b1 || running !== 1'b0 || expire_pulse !== 1'b0) begin
      n_mis++; $display("FAIL exp_state: got exp=%b run=%b pulse=%b need 1/0/0", expired, running, expire_pulse);
    end
    tick_wait(lat, obs, p);
    n_cmp++;
    if (obs !== 8'h00 || expired !== 1'b1) begin
      n_mis++; $display("FAIL exp_sticky: got count=%h exp=%b need 00/1", obs, expired);
    end
    n_cmp++;
    if (pulse_cnt - pc0 !== 1) begin n_mis++; $display("FAIL exp_pulse_count: got %0d need 1", pulse_cnt - pc0); end
  endtask

  task automatic test_pause();
    int lat; logic [7:0] obs; logic p; logic [7:0] e;
    do_load(8'h05); do_start();
    exp_q.push_back(8'h04);
    tick_wait(lat, obs, p);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e || running !== 1'b1) begin
      n_mis++; $display("FAIL pz_first: got count=%h run=%b need %h/1", obs, running, e);
    end
    pause = 1'b1; step(); pause = 1'b0;
    n_cmp++;
    if (running !== 1'b0) begin n_mis++; $display("FAIL pz_running: got %b need 0", running); end
    for (int i = 0; i < 3; i++) begin
      tick_wait(lat, obs, p);
      n_cmp++;
      if (obs !== 8'h04) begin n_mis++; $display("FAIL pz_hold[%0d]: got %h need 04", i, obs); end
    end
    do_start();
    n_cmp++;
    if (running !== 1'b1) begin n_mis++; $display("FAIL pz_resume: got %b need 1", running); end
    exp_q.push_back(8'h03);
    tick_wait(lat, obs, p);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_mis++; $display("FAIL pz_after: got %h need %h", obs, e); end
  endtask

  task automatic test_priority();
    int pc0;
    do_load(8'h07); do_start();
    pc0 = pulse_cnt;
    clear = 1'b1; load = 1'b1; start = 1'b1; load_value = 8'h55;
    step();
    clear = 1'b0; load = 1'b0; start = 1'b0;
    step();
    n_cmp++;
    if (count_bcd !== 8'h00 || running !== 1'b0 || expired !== 1'b0 || pulse_cnt !== pc0) begin
      n_mis++;
      $display("FAIL prio: got count=%h run=%b exp=%b pulses=%0d need 00/0/0/%0d",
               count_bcd, running, expired, pulse_cnt, pc0);
    end
  endtask

  task automatic test_clamp_zero_start();
    int pc0;
    do_load(8'hAF);
    n_cmp++;
    if (count_bcd !== 8'h99) begin n_mis++; $display("FAIL clamp_af: got %h need 99", count_bcd); end
    do_load(8'hA5);
    n_cmp++;
    if (count_bcd !== 8'h95) begin n_mis++; $display("FAIL clamp_a5: got %h need 95", count_bcd); end
    clear = 1'b1; step(); clear = 1'b0;
    pc0 = pulse_cnt;
    do_start();
    n_cmp++;
    if (expired !== 1'b1 || expire_pulse !== 1'b1 || count_bcd !== 8'h00) begin
      n_mis++; $display("FAIL zero_start: got exp=%b pulse=%b count=%h need 1/1/00", expired, expire_pulse, count_bcd);
    end
    step();
    n_cmp++;
    if (expire_pulse !== 1'b0 || expired !== 1'b1 || pulse_cnt - pc0 !== 1) begin
      n_mis++; $display("FAIL zero_start_once: got pulse=%b exp=%b pulses=%0d need 0/1/1",
                        expire_pulse, expired, pulse_cnt - pc0);
    end
  endtask

  task automatic test_reset_midrun();
    int lat; logic [7:0] obs; logic p;
    do_load(8'h30); do_start();
    tick_in = 1'b1;
    step();
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({count_bcd, running, expired, expire_pulse} !== 11'd0) begin
      n_mis++; $display("FAIL rst_mid: got count=%h run=%b exp=%b pulse=%b need all 0",
                        count_bcd, running, expired, expire_pulse);
    end
    repeat (2) step();
    @(negedge refclk); resetn = 1'b1;
    repeat (6) step();
    n_cmp++;
    if (count_bcd !== 8'h00 || running !== 1'b0 || expired !== 1'b0) begin
      n_mis++; $display("FAIL rst_release_tick: got count=%h run=%b exp=%b need 00/0/0", count_bcd, running, expired);
    end
    tick_in = 1'b0;
    repeat (4) step();
    do_load(8'h30);
    tick_wait(lat, obs, p);
    n_cmp++;
    if (obs !== 8'h30 || running !== 1'b0) begin
      n_mis++; $display("FAIL rst_no_start: got count=%h run=%b need 30/0", obs, running);
    end
  endtask

  initial begin
    repeat (3) @(posedge refclk);
    #1;
    test_reset();
    test_countdown();
    test_expire();
    test_pause();
    test_priority();
    test_clamp_zero_start();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
